// File: rtl/serial_alu_pkg.sv
// Shared opcode encodings and FSM state type for the bit-serial ALU.
// Optional flags build: SERIAL_ALU_FLAGS_EN adds zero/ovf outputs.
package serial_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_arith(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/serial_alu_if.sv
// Request/response bundle of the bit-serial ALU.
// Optional flags build: SERIAL_ALU_FLAGS_EN adds zero/ovf.
interface serial_alu_if #(
  parameter int WIDTH = 8
);
  // Handshake: start is sampled at a rising edge only while busy is low
  // (IDLE or DONE); a, b, opcode and cin are captured at that same edge.
  // busy stays high for exactly WIDTH cycles, then done pulses for one cycle
  // with result/cout (and flags) freshly updated; they hold until the next done.
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       opcode;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
`ifdef SERIAL_ALU_FLAGS_EN
  logic             zero;
  logic             ovf;
`endif

  modport master (
    output start, a, b, opcode, cin,
`ifdef SERIAL_ALU_FLAGS_EN
    input  zero, ovf,
`endif
    input  busy, done, result, cout
  );

  modport slave (
    input  start, a, b, opcode, cin,
`ifdef SERIAL_ALU_FLAGS_EN
    output zero, ovf,
`endif
    output busy, done, result, cout
  );

endinterface

// File: rtl/serial_alu_bit_slice.sv
// Combinational 1-bit ALU slice: full adder for ADD/SUB (b inverted for SUB),
// plain gate for AND/OR with carry-out forced low.
module alu_bit_slice
  import serial_alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [1:0] opcode,
  input  logic       cin,
  output logic       r,
  output logic       co
);

  logic b_eff;

  always_comb begin
    b_eff = (opcode == OP_SUB) ? ~b : b;
    r     = 1'b0;
    co    = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB: begin
        r  = a ^ b_eff ^ cin;
        co = (a & b_eff) | (cin & (a ^ b_eff));
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      default: begin
        r  = 1'b0;
        co = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: WIDTH-bit ADD/SUB/AND/OR, one bit per cycle LSB first.
// Optional flags build: define SERIAL_ALU_FLAGS_EN for zero/ovf outputs.
module serial_alu
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_alu_if.slave  bus,
  output state_t       state_dbg
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   acc;
  logic [1:0]         op_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   result_q;
  logic               cout_q;
`ifdef SERIAL_ALU_FLAGS_EN
  logic               zero_q;
  logic               ovf_q;
`endif

  logic               slice_r;
  logic               slice_co;
  logic [WIDTH-1:0]   acc_next;

  alu_bit_slice u_slice (
    .a      (a_sh[0]),
    .b      (b_sh[0]),
    .opcode (op_q),
    .cin    (carry),
    .r      (slice_r),
    .co     (slice_co)
  );

  // Result bits enter at the MSB so after WIDTH shifts bit 0 lands at position 0.
  assign acc_next = {slice_r, acc[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      carry    <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      acc      <= '0;
      op_q     <= OP_ADD;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ALU_FLAGS_EN
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            op_q   <= bus.opcode;
            cnt    <= '0;
            acc    <= '0;
            case (bus.opcode)
              OP_ADD:  carry <= bus.cin;
              OP_SUB:  carry <= 1'b1;
              default: carry <= 1'b0;
            endcase
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          acc   <= acc_next;
          carry <= slice_co;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            result_q <= acc_next;
            cout_q   <= is_arith(op_q) ? slice_co : 1'b0;
`ifdef SERIAL_ALU_FLAGS_EN
            zero_q   <= (acc_next == '0);
            // Signed overflow: carry into the MSB differs from carry out of it.
            ovf_q    <= is_arith(op_q) ? (carry ^ slice_co) : 1'b0;
`endif
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
`ifdef SERIAL_ALU_FLAGS_EN
  assign bus.zero   = zero_q;
  assign bus.ovf    = ovf_q;
`endif
  assign state_dbg  = state;

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu: directed cases plus randomized ops
// against an arithmetic reference model. Define SERIAL_ALU_FLAGS_EN to cover flags.
module tb_serial_alu;
  import serial_alu_pkg::*;

  localparam int W = 8;
  localparam int LAT = W + 1;
  localparam int BUDGET = 40;

  logic   clk;
  logic   rst_n;
  state_t state_dbg;
  int     tests_run;
  int     tests_failed;

  serial_alu_if #(.WIDTH(W)) bus ();

  serial_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: returns {ovf, cout, result}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] op, input logic ci);
    logic [W:0]   full;
    logic         ovf;
    full = '0;
    ovf  = 1'b0;
    case (op)
      OP_ADD: begin
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
      end
      OP_SUB: begin
        full[W-1:0] = a - b;
        full[W]     = (a >= b);
        ovf         = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
      end
      OP_AND: full = {1'b0, a & b};
      default: full = {1'b0, a | b};
    endcase
    return {ovf, full};
  endfunction

  // ---------------- driver ----------------
  // Issues one op and waits for done; returns at the falling edge of the done cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                        input logic ci, output int lat, output int busy_cnt);
    bus.a      = a;
    bus.b      = b;
    bus.opcode = op;
    bus.cin    = ci;
    bus.start  = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    for (int n = 1; n <= BUDGET; n++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = n;
        break;
      end
      if (bus.busy) busy_cnt++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.opcode = OP_ADD;
    bus.cin   = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0 || bus.cout !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs busy=%b done=%b result=%h cout=%b, required 0 0 00 0",
               bus.busy, bus.done, bus.result, bus.cout);
    end
    tests_run++;
    if (state_dbg !== IDLE) begin
      tests_failed++;
      $display("FAIL reset_state got %0d required %0d", state_dbg, IDLE);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset busy=%b done=%b required 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [7] = '{8'h7F, 8'hFF, 8'h05, 8'h05, 8'hF0, 8'hF0, 8'h10};
    logic [W-1:0] tb_ [7] = '{8'h01, 8'h01, 8'h07, 8'h05, 8'h3C, 8'h3C, 8'h20};
    logic [1:0]   top [7] = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_AND, OP_OR, OP_SUB};
    logic         tci [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [W-1:0] er  [7] = '{8'h80, 8'h01, 8'hFE, 8'h00, 8'h30, 8'hFC, 8'hF0};
    logic         ec  [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int lat, bc;
    for (int i = 0; i < 7; i++) begin
      run_op(ta[i], tb_[i], top[i], tci[i], lat, bc);
      tests_run++;
      if (lat !== LAT || bc !== W) begin
        tests_failed++;
        $display("FAIL directed_latency[%0d] done_after=%0d busy_cycles=%0d required %0d %0d",
                 i, lat, bc, LAT, W);
      end
      tests_run++;
      if (bus.result !== er[i] || bus.cout !== ec[i]) begin
        tests_failed++;
        $display("FAIL directed_result[%0d] result=%h cout=%b required %h %b",
                 i, bus.result, bus.cout, er[i], ec[i]);
      end
`ifdef SERIAL_ALU_FLAGS_EN
      tests_run++;
      if (bus.zero !== (er[i] == '0) ||
          bus.ovf !== ((i == 0) ? 1'b1 : 1'b0)) begin
        tests_failed++;
        $display("FAIL directed_flags[%0d] zero=%b ovf=%b", i, bus.zero, bus.ovf);
      end
`endif
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] prev;
    int done_cnt, done_at;
    logic held_ok;
    prev       = bus.result;
    bus.a      = 8'h10;
    bus.b      = 8'h20;
    bus.opcode = OP_ADD;
    bus.cin    = 1'b0;
    bus.start  = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    done_cnt = 0;
    done_at  = 0;
    held_ok  = 1'b1;
    for (int n = 1; n <= LAT + 6; n++) begin
      @(negedge clk);
      if (n == 3) begin
        bus.a = 8'hAA; bus.b = 8'h55; bus.opcode = OP_OR; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        done_cnt++;
        done_at = n;
      end
      if (n < LAT && bus.result !== prev) held_ok = 1'b0;
    end
    tests_run++;
    if (done_cnt !== 1 || done_at !== LAT) begin
      tests_failed++;
      $display("FAIL ignore_start_pulses count=%0d at=%0d required 1 at %0d", done_cnt, done_at, LAT);
    end
    tests_run++;
    if (bus.result !== 8'h30 || bus.cout !== 1'b0) begin
      tests_failed++;
      $display("FAIL ignore_start_result result=%h cout=%b required 30 0", bus.result, bus.cout);
    end
    tests_run++;
    if (!held_ok) begin
      tests_failed++;
      $display("FAIL result_held_during_run result changed, required %h held", prev);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, lat2;
    run_op(8'h20, 8'h01, OP_SUB, 1'b0, lat, bc);
    tests_run++;
    if (lat !== LAT || bus.result !== 8'h1F) begin
      tests_failed++;
      $display("FAIL b2b_first lat=%0d result=%h required %0d 1f", lat, bus.result, LAT);
    end
    bus.a = 8'h0A; bus.b = 8'h03; bus.opcode = OP_SUB; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b1 || state_dbg !== RUN) begin
      tests_failed++;
      $display("FAIL b2b_no_gap busy=%b state=%0d required 1 %0d", bus.busy, state_dbg, RUN);
    end
    lat2 = 0;
    for (int n = 1; n <= BUDGET; n++) begin
      @(negedge clk);
      if (bus.done) begin
        lat2 = n;
        break;
      end
    end
    tests_run++;
    if (lat2 !== LAT || bus.result !== 8'h07 || bus.cout !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_second lat=%0d result=%h cout=%b required %0d 07 1",
               lat2, bus.result, bus.cout, LAT);
    end
  endtask

  task automatic test_async_reset();
    int dones, lat, bc;
    bus.a = 8'h33; bus.b = 8'h44; bus.opcode = OP_ADD; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0 || bus.cout !== 1'b0 ||
        state_dbg !== IDLE) begin
      tests_failed++;
      $display("FAIL async_reset busy=%b done=%b result=%h cout=%b state=%0d required 0 0 00 0 0",
               bus.busy, bus.done, bus.result, bus.cout, state_dbg);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("FAIL aborted_no_done pulses=%0d required 0", dones);
    end
    run_op(8'h03, 8'h04, OP_ADD, 1'b0, lat, bc);
    tests_run++;
    if (lat !== LAT || bus.result !== 8'h07 || bus.cout !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_reset_op lat=%0d result=%h cout=%b required %0d 07 0",
               lat, bus.result, bus.cout, LAT);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    logic [1:0]   rop;
    logic         rci;
    logic [W+1:0] exp_v;
    int lat, bc;
    for (int i = 0; i < 40; i++) begin
      ra    = W'($urandom);
      rb    = W'($urandom);
      rop   = 2'($urandom_range(0, 3));
      rci   = 1'($urandom_range(0, 1));
      exp_v = model(ra, rb, rop, rci);
      run_op(ra, rb, rop, rci, lat, bc);
      tests_run++;
      if (lat !== LAT || bus.result !== exp_v[W-1:0] || bus.cout !== exp_v[W]) begin
        tests_failed++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h cin=%b lat=%0d result=%h cout=%b required %0d %h %b",
                 i, rop, ra, rb, rci, lat, bus.result, bus.cout, LAT, exp_v[W-1:0], exp_v[W]);
      end
`ifdef SERIAL_ALU_FLAGS_EN
      tests_run++;
      if (bus.zero !== (exp_v[W-1:0] == '0) || bus.ovf !== exp_v[W+1]) begin
        tests_failed++;
        $display("FAIL random_flags[%0d] zero=%b ovf=%b required %b %b",
                 i, bus.zero, bus.ovf, (exp_v[W-1:0] == '0), exp_v[W+1]);
      end
`endif
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    test_random();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
